// File: rtl/cwp_pkg.sv
// Shared types and constants for the current-window-pointer unit.
package cwp_pkg;

  localparam int unsigned NWIN_DEFAULT = 8;
  localparam int unsigned NWIN_MIN     = 2;
  localparam int unsigned NWIN_MAX     = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } cwp_state_e;

endpackage

// File: rtl/cwp_modstep.sv
// Modulo-NWIN increment/decrement of a window pointer; correct for non-power-of-two NWIN.
module cwp_modstep #(
  parameter  int unsigned NWIN = 8,
  localparam int unsigned CWPW = $clog2(NWIN)
) (
  input  logic [CWPW-1:0] cwp_i,
  output logic [CWPW-1:0] cwp_p1_c,
  output logic [CWPW-1:0] cwp_m1_c
);

  localparam logic [CWPW-1:0] LAST = CWPW'(NWIN - 1);

  // Explicit wrap at the ends instead of relying on 2^CWPW overflow.
  always_comb begin
    cwp_p1_c = (cwp_i == LAST) ? '0 : cwp_i + CWPW'(1);
    cwp_m1_c = (cwp_i == '0) ? LAST : cwp_i - CWPW'(1);
  end

endmodule

// File: rtl/cwp_window_unit.sv
// Current window pointer with SAVE/RESTORE stepping, trap entry and direct write.
// Window overflow/underflow trap checking is built only when CWP_TRAP_CHECK_EN is defined.
module cwp_window_unit
  import cwp_pkg::*;
#(
  parameter  int unsigned NWIN = NWIN_DEFAULT,
  localparam int unsigned CWPW = $clog2(NWIN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            save_i,
  input  logic            restore_i,
  input  logic            trap_entry_i,
  input  logic            wrcwp_vld_i,
  input  logic [CWPW-1:0] wrcwp_data_i,
  input  logic [NWIN-1:0] wim_i,
  input  logic            trap_ack_i,
  output logic [CWPW-1:0] cwp_o,
  output logic [CWPW-1:0] cwp_p1_o,
  output logic [CWPW-1:0] cwp_m1_o,
  output logic            ovf_o,
  output logic            unf_o,
  output logic            trap_pend_o,
  output logic            err_o
);

  if ((NWIN < NWIN_MIN) || (NWIN > NWIN_MAX)) begin : g_bad_nwin
    $error("cwp_window_unit: NWIN out of legal range 2..32");
  end

  localparam logic [CWPW:0] NWIN_EXT = (CWPW+1)'(NWIN);

  logic [CWPW-1:0] cwp_q, cwp_d;
  logic            err_q, err_d;
  logic            ovf_d, unf_d;
  logic [CWPW-1:0] cwp_p1_c, cwp_m1_c;
  logic            wr_in_range_c;
  logic            idle_c;
  logic            save_trap_c, restore_trap_c;

  cwp_modstep #(.NWIN(NWIN)) u_modstep (
    .cwp_i    (cwp_q),
    .cwp_p1_c (cwp_p1_c),
    .cwp_m1_c (cwp_m1_c)
  );

  assign wr_in_range_c = ({1'b0, wrcwp_data_i} < NWIN_EXT);

  // Priority: direct write > trap entry > save/restore (latter only when no trap is pending).
  always_comb begin
    cwp_d = cwp_q;
    err_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (wrcwp_vld_i) begin
      if (wr_in_range_c) cwp_d = wrcwp_data_i;
      else               err_d = 1'b1;
    end else if (trap_entry_i) begin
      cwp_d = cwp_m1_c;
    end else if (idle_c) begin
      if (save_i && restore_i) begin
        err_d = 1'b1;
      end else if (save_i) begin
        if (save_trap_c) ovf_d = 1'b1;
        else             cwp_d = cwp_m1_c;
      end else if (restore_i) begin
        if (restore_trap_c) unf_d = 1'b1;
        else                cwp_d = cwp_p1_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp_q <= '0;
      err_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      err_q <= err_d;
    end
  end

  assign cwp_o    = cwp_q;
  assign cwp_p1_o = cwp_p1_c;
  assign cwp_m1_o = cwp_m1_c;
  assign err_o    = err_q;

`ifdef CWP_TRAP_CHECK_EN
  cwp_state_e state_q, state_d;
  logic       ovf_q, unf_q;

  assign idle_c         = (state_q == IDLE);
  assign save_trap_c    = wim_i[cwp_m1_c];
  assign restore_trap_c = wim_i[cwp_p1_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // A pending trap only clears on handler acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ovf_d || unf_d) state_d = PEND;
      PEND:    if (trap_ack_i)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trap_pend_o = (state_q == PEND);
    ovf_o       = ovf_q;
    unf_o       = unf_q;
  end
`else
  logic unused_c;

  assign idle_c         = 1'b1;
  assign save_trap_c    = 1'b0;
  assign restore_trap_c = 1'b0;
  assign unused_c       = ^{wim_i, trap_ack_i, ovf_d, unf_d};

  assign trap_pend_o = 1'b0;
  assign ovf_o       = 1'b0;
  assign unf_o       = 1'b0;
`endif

endmodule

// File: tb/tb_cwp_window_unit.sv
// Scoreboard bench for cwp_window_unit: NWIN=8, 7 and 6 instances, directed vectors.
// Expectations follow the build: trap checking is active when CWP_TRAP_CHECK_EN is defined.
module tb_cwp_window_unit;

`ifdef CWP_TRAP_CHECK_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [2:0] cwp;
    logic       ovf;
    logic       unf;
    logic       pend;
    logic       err;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       save, restore, trap_e, wr, ack;
  logic [2:0] wdata;
  logic [7:0] wim;
  logic [2:0] en;

  logic [2:0] cwp8, p18, m18, cwp7, p17, m17, cwp6, p16, m16;
  logic       ovf8, unf8, pend8, err8, ovf7, unf7, pend7, err7, ovf6, unf6, pend6, err6;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign en = 3'b001 << sel;

  cwp_window_unit #(.NWIN(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .save_i(save & en[0]), .restore_i(restore & en[0]), .trap_entry_i(trap_e & en[0]),
    .wrcwp_vld_i(wr & en[0]), .wrcwp_data_i(wdata), .wim_i(wim), .trap_ack_i(ack & en[0]),
    .cwp_o(cwp8), .cwp_p1_o(p18), .cwp_m1_o(m18), .ovf_o(ovf8), .unf_o(unf8),
    .trap_pend_o(pend8), .err_o(err8)
  );

  cwp_window_unit #(.NWIN(7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .save_i(save & en[1]), .restore_i(restore & en[1]), .trap_entry_i(trap_e & en[1]),
    .wrcwp_vld_i(wr & en[1]), .wrcwp_data_i(wdata), .wim_i(wim[6:0]), .trap_ack_i(ack & en[1]),
    .cwp_o(cwp7), .cwp_p1_o(p17), .cwp_m1_o(m17), .ovf_o(ovf7), .unf_o(unf7),
    .trap_pend_o(pend7), .err_o(err7)
  );

  cwp_window_unit #(.NWIN(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .save_i(save & en[2]), .restore_i(restore & en[2]), .trap_entry_i(trap_e & en[2]),
    .wrcwp_vld_i(wr & en[2]), .wrcwp_data_i(wdata), .wim_i(wim[5:0]), .trap_ack_i(ack & en[2]),
    .cwp_o(cwp6), .cwp_p1_o(p16), .cwp_m1_o(m16), .ovf_o(ovf6), .unf_o(unf6),
    .trap_pend_o(pend6), .err_o(err6)
  );

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    logic [2:0] a_cwp, a_p1, a_m1;
    logic       a_ovf, a_unf, a_pend, a_err;
    int         n;
    case (e.id)
      0: begin n = 8; a_cwp = cwp8; a_p1 = p18; a_m1 = m18;
               a_ovf = ovf8; a_unf = unf8; a_pend = pend8; a_err = err8; end
      1: begin n = 7; a_cwp = cwp7; a_p1 = p17; a_m1 = m17;
               a_ovf = ovf7; a_unf = unf7; a_pend = pend7; a_err = err7; end
      default: begin n = 6; a_cwp = cwp6; a_p1 = p16; a_m1 = m16;
               a_ovf = ovf6; a_unf = unf6; a_pend = pend6; a_err = err6; end
    endcase
    chk(e.name, "cwp",  8'(a_cwp), 8'(e.cwp));
    chk(e.name, "p1",   8'(a_p1),  8'((int'(e.cwp) + 1) % n));
    chk(e.name, "m1",   8'(a_m1),  8'((int'(e.cwp) + n - 1) % n));
    chk(e.name, "ovf",  8'(a_ovf), 8'(e.ovf));
    chk(e.name, "unf",  8'(a_unf), 8'(e.unf));
    chk(e.name, "pend", 8'(a_pend), 8'(e.pend));
    chk(e.name, "err",  8'(a_err), 8'(e.err));
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e);
      end
    end
  end

  task automatic step(input int id, input logic sv, input logic rs, input logic te,
                      input logic w, input logic [2:0] wd, input logic [7:0] wm, input logic ak,
                      input logic [2:0] ecwp, input logic eovf, input logic eunf,
                      input logic epend, input logic eerr, input string nm);
    @(negedge clk);
    sel = 2'(id); save = sv; restore = rs; trap_e = te; wr = w; wdata = wd; wim = wm; ack = ak;
    sb.push_back('{id, ecwp, eovf, eunf, epend, eerr, nm});
  endtask

  task automatic quiet();
    save = 1'b0; restore = 1'b0; trap_e = 1'b0; wr = 1'b0; ack = 1'b0; wdata = '0; wim = '0;
  endtask

  task automatic check_reset(input string nm);
    for (int i = 0; i < 3; i++) compare('{i, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm});
  endtask

  initial begin
    sel = 2'd0;
    quiet();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Eight saves from reset walk 7..0.
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, 0, 3'd0, 8'h00, 0, 3'(7 - i), 0, 0, 0, 0, "save_seq");

    step(0, 0, 0, 0, 1, 3'd3, 8'h00, 0, 3'd3, 0, 0, 0, 0, "wr3");
    step(0, 1, 0, 0, 0, 3'd0, 8'h04, 0, T ? 3'd3 : 3'd2, T, 0, T, 0, "save_ovf");
    step(0, 0, 1, 0, 0, 3'd0, 8'h04, 0, 3'd3, 0, 0, T, 0, "restore_in_pend");
    step(0, 1, 1, 0, 0, 3'd0, 8'h04, 0, 3'd3, 0, 0, T, !T, "both_in_pend");
    step(0, 0, 0, 0, 0, 3'd0, 8'h04, 1, 3'd3, 0, 0, 0, 0, "ack");
    step(0, 0, 0, 1, 0, 3'd0, 8'h04, 0, 3'd2, 0, 0, 0, 0, "trap_entry");
    step(0, 0, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 0, 0, 0, "ack_idle");
    step(0, 1, 0, 0, 0, 3'd0, 8'h02, 0, T ? 3'd2 : 3'd1, T, 0, T, 0, "save_ovf2");
    step(0, 1, 0, 0, 0, 3'd0, 8'h02, 1, T ? 3'd2 : 3'd0, 0, 0, 0, 0, "ack_with_save");

    step(0, 0, 0, 0, 1, 3'd7, 8'h00, 0, 3'd7, 0, 0, 0, 0, "wr7");
    step(0, 0, 1, 0, 0, 3'd0, 8'h01, 0, T ? 3'd7 : 3'd0, 0, T, T, 0, "restore_unf");
    step(0, 0, 1, 0, 1, 3'd5, 8'h01, 0, 3'd5, 0, 0, T, 0, "wr_over_restore");
    step(0, 0, 0, 0, 0, 3'd0, 8'h00, 1, 3'd5, 0, 0, 0, 0, "ack2");
    step(0, 1, 0, 1, 0, 3'd0, 8'h00, 0, 3'd4, 0, 0, 0, 0, "trap_over_save");
    step(0, 0, 0, 1, 1, 3'd1, 8'h00, 0, 3'd1, 0, 0, 0, 0, "wr_over_trap");
    step(0, 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 0, "wr0");
    step(0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 3'd7, 0, 0, 0, 0, "trap_wrap");
    step(0, 1, 1, 0, 0, 3'd0, 8'h00, 0, 3'd7, 0, 0, 0, 1, "both_idle");

    // Reset while a trap is pending, then a save must step as from IDLE.
    step(0, 0, 0, 0, 1, 3'd4, 8'h00, 0, 3'd4, 0, 0, 0, 0, "wr4");
    step(0, 1, 0, 0, 0, 3'd0, 8'h08, 0, T ? 3'd4 : 3'd3, T, 0, T, 0, "save_ovf3");
    @(negedge clk);
    quiet();
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_pend");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0, 3'd0, 8'h00, 0, 3'd7, 0, 0, 0, 0, "save_after_reset");
    step(0, 1, 0, 0, 0, 3'd0, 8'hFF, 0, T ? 3'd7 : 3'd6, T, 0, T, 0, "save_wim_ff");
    step(0, 1, 0, 0, 0, 3'd0, 8'hFF, 0, T ? 3'd7 : 3'd5, 0, 0, T, 0, "save_wim_ff2");
    step(0, 0, 0, 0, 0, 3'd0, 8'h00, 1, T ? 3'd7 : 3'd5, 0, 0, 0, 0, "ack3");

    // NWIN=7 wrap in both directions.
    step(1, 1, 0, 0, 0, 3'd0, 8'h00, 0, 3'd6, 0, 0, 0, 0, "n7_save_wrap");
    step(1, 0, 1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 0, "n7_restore_wrap");
    step(1, 0, 0, 0, 1, 3'd6, 8'h00, 0, 3'd6, 0, 0, 0, 0, "n7_wr6");
    step(1, 0, 1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 0, "n7_restore6");
    step(1, 0, 0, 0, 1, 3'd7, 8'h00, 0, 3'd0, 0, 0, 0, 1, "n7_wr_oob");

    // NWIN=6 out-of-range writes and conflicting requests.
    step(2, 0, 0, 0, 1, 3'd6, 8'h00, 0, 3'd0, 0, 0, 0, 1, "n6_wr6");
    step(2, 0, 0, 0, 1, 3'd5, 8'h00, 0, 3'd5, 0, 0, 0, 0, "n6_wr5");
    step(2, 1, 1, 0, 0, 3'd0, 8'h00, 0, 3'd5, 0, 0, 0, 1, "n6_both");
    step(2, 0, 0, 0, 1, 3'd7, 8'h00, 0, 3'd5, 0, 0, 0, 1, "n6_wr7");
    step(2, 0, 1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 0, "n6_restore_wrap");
    step(2, 1, 0, 0, 0, 3'd0, 8'h00, 0, 3'd5, 0, 0, 0, 0, "n6_save_wrap");

    @(negedge clk);
    quiet();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
